d_ff: RTL and testbench
=======================

D_FF -- requirements
Module: d_ff

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clock port clk, reset port reset.
REQ-002 Parameter WIDTH, default 1: number of independent storage bits.
REQ-003 Parameter RESET_VALUE, default all-zeros, WIDTH bits: value forced onto q by reset.
REQ-004 clk  input  1  rising-edge sampling clock.
REQ-005 reset  input  1  asynchronous active-high clear to RESET_VALUE.
REQ-006 d  input  WIDTH  data sampled at the rising edge of clk.
REQ-007 q  output  WIDTH  registered state, driven only by the storage element.
REQ-008 With default parameters the port list SHALL be exactly q, d, reset, clk (single bit each), so instantiation by named ports works without overrides.

Function
REQ-009 At each rising edge of clk with reset low, q SHALL take the value d held at that edge; latency is one clock edge.
REQ-010 Falling clock edges, and changes on d between rising edges, SHALL NOT change q.
REQ-011 No combinational path SHALL exist from d to q; q changes only at a rising clk edge or on reset assertion.
REQ-012 Each bit of q SHALL depend only on the same-index bit of d; bits SHALL NOT interact.
REQ-013 An enable SHALL NOT be built in; enable behaviour is formed outside the block by mux2_1 (sel=en, in={d, q}, out feeding d).
REQ-014 mux2_1 SHALL pass in[1] when sel=1 and in[0] when sel=0, so en=1 loads new data and en=0 recirculates q.
REQ-015 With reset tied to constant 0, the block SHALL behave as a plain rising-edge D flip-flop with no reset activity.
REQ-016 Before the first rising clk edge or reset assertion, q is unspecified (X in simulation); no initial value SHALL be relied on.

Reset
REQ-017 Reset assertion SHALL force q to RESET_VALUE immediately, independent of clk and without waiting for an edge.
REQ-018 While reset is high, q SHALL hold RESET_VALUE and ignore clk edges and d.
REQ-019 On reset deassertion, q SHALL hold RESET_VALUE until the next rising clk edge with reset low, then capture d.
REQ-020 If reset and a rising clk edge occur at the same time, reset SHALL take priority and q SHALL equal RESET_VALUE.
REQ-021 Reset asserted between clock edges SHALL clear q at once and discard the previously captured value.

Verification
REQ-022 Capture: reset=0, d toggled 0->1->0 on successive rising edges -> q follows with one-edge delay (0,1,0); q never changes on falling edges.
REQ-023 Asynchronous reset: q=1, reset pulsed high mid-cycle -> q=0 immediately; q stays 0 through clk edges while reset is high; with d=1, q=1 at the first rising edge after release.
REQ-024 Enable composition: 64 instances of d_ff and mux2_1 form a 64-bit register with en and reset=0, clock period 100 ns; the bench SHALL apply the steps below in this order:
  - en=1, d=0x0 -> q=0x0.
  - d=0x1 -> q=0x1 after the next rising edge.
  - en=0, d=0xA, then d=0xF -> q holds 0x1 for 6 edges.
  - en=1, d=0x10 -> q=0x10 after the next rising edge.
REQ-025 Parameters: WIDTH=8, RESET_VALUE=0xA5, reset pulsed -> q=0xA5; after reset release with d=0x3C, q=0x3C at the next rising edge.
REQ-026 Simultaneous events: reset rises in the same timestep as a clk rising edge with d=1 -> q=RESET_VALUE, never d.

Source files
------------

// File: rtl/d_ff.sv
// Rising-edge D flip-flop bank with asynchronous active-high reset,
// plus the 2:1 mux that builds an enabled register around it outside the flop.

module d_ff #(
   parameter int              WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   output logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             reset,
   input  logic             clk
);

   // Reset is in the sensitivity list so it wins over a coincident clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= RESET_VALUE;
      else
         q <= d;
   end

endmodule

module mux2_1 (
   input  logic       sel,
   input  logic [1:0] in,
   output logic       out
);

   assign out = sel ? in[1] : in[0];

endmodule

// File: tb/tb_d_ff.sv
// Directed self-checking bench for d_ff: capture, async reset, reset/clock
// collision, a parameterised reset value and a 64-bit enabled register.
`timescale 1ns/1ps

module tb_d_ff;

   logic clk;
   logic reset_a, d_a, q_a;
   logic reset_b;
   logic [7:0] d_b, q_b;
   logic en;
   logic [63:0] d_c, q_c, mux_c;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #50 clk = ~clk;

   d_ff dut_a (
      .q(q_a),
      .d(d_a),
      .reset(reset_a),
      .clk(clk)
   );

   d_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut_b (
      .q(q_b),
      .d(d_b),
      .reset(reset_b),
      .clk(clk)
   );

   for (genvar i = 0; i < 64; i++) begin : g_reg
      mux2_1 u_mux (
         .sel(en),
         .in({d_c[i], q_c[i]}),
         .out(mux_c[i])
      );
      d_ff u_ff (
         .q(q_c[i]),
         .d(mux_c[i]),
         .reset(1'b0),
         .clk(clk)
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_a = 1'b0;
      d_a     = 1'b0;
      reset_b = 1'b0;
      d_b     = 8'h00;
      en      = 1'b1;
      d_c     = 64'h0;

      #5;
      reset_a = 1'b1;
      reset_b = 1'b1;
      #1;
      check_output("reset_state_a", {63'b0, q_a}, 64'h0);
      check_output("reset_value_b", {56'b0, q_b}, 64'hA5);

      // Clock edges while reset is held must not load d.
      d_a = 1'b1;
      d_b = 8'h3C;
      tick();
      check_output("hold_in_reset_a", {63'b0, q_a}, 64'h0);
      check_output("hold_in_reset_b", {56'b0, q_b}, 64'hA5);
      check_output("en_load_0", q_c, 64'h0);

      reset_a = 1'b0;
      reset_b = 1'b0;
      d_a     = 1'b0;
      #1;
      check_output("release_holds_b", {56'b0, q_b}, 64'hA5);

      d_c = 64'h1;
      tick();
      check_output("capture_0", {63'b0, q_a}, 64'h0);
      check_output("param_capture_b", {56'b0, q_b}, 64'h3C);
      check_output("en_load_1", q_c, 64'h1);

      en  = 1'b0;
      d_c = 64'hA;
      d_a = 1'b1;
      tick();
      check_output("capture_1", {63'b0, q_a}, 64'h1);
      check_output("en_hold_1", q_c, 64'h1);

      @(negedge clk);
      #1;
      check_output("negedge_no_change", {63'b0, q_a}, 64'h1);
      d_a = 1'b0;
      #10;
      check_output("d_change_no_effect", {63'b0, q_a}, 64'h1);

      tick();
      check_output("capture_back_0", {63'b0, q_a}, 64'h0);
      check_output("en_hold_2", q_c, 64'h1);

      tick();
      check_output("en_hold_3", q_c, 64'h1);
      d_c = 64'hF;
      for (int k = 4; k <= 6; k++) begin
         d_a = 1'b1;
         tick();
         check_output($sformatf("en_hold_%0d", k), q_c, 64'h1);
      end
      check_output("capture_before_async", {63'b0, q_a}, 64'h1);

      en  = 1'b1;
      d_c = 64'h10;
      tick();
      check_output("en_reload_10", q_c, 64'h10);

      // Mid-cycle reset must clear without waiting for an edge.
      #20;
      reset_a = 1'b1;
      #1;
      check_output("async_clear", {63'b0, q_a}, 64'h0);
      tick();
      check_output("reset_high_edge", {63'b0, q_a}, 64'h0);
      reset_a = 1'b0;
      #1;
      check_output("release_holds_a", {63'b0, q_a}, 64'h0);
      tick();
      check_output("first_edge_after_release", {63'b0, q_a}, 64'h1);

      // Reset rising in the same timestep as a clock edge.
      d_a = 1'b1;
      tick();
      check_output("pre_collision", {63'b0, q_a}, 64'h1);
      @(posedge clk);
      reset_a = 1'b1;
      #1;
      check_output("collision_reset_wins", {63'b0, q_a}, 64'h0);
      reset_a = 1'b0;
      tick();
      check_output("post_collision_capture", {63'b0, q_a}, 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
